// File: rtl/pulse_stretch_pkg.sv
// pulse_stretch_pkg
//   Shared definitions for the pulse stretcher: FSM state encoding and the
//   default parameter values used by pulse_stretch_fsm.
package pulse_stretch_pkg;

  localparam int HIGH_CYCLES_DEF = 8;
  localparam int GAP_CYCLES_DEF  = 2;
  localparam int CW_DEF          = 8;

  // 2-bit encoding; 2'b11 is illegal and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HIGH = 2'b01,
    GAP  = 2'b10
  } state_t;

endpackage

// File: rtl/pulse_stretch_cnt.sv
// pulse_stretch_cnt
//   Loadable CW-bit down-counter. Load has priority over decrement.
//   clk      in   system clock
//   reset_n  in   async active-low reset, clears count to 0
//   load     in   load load_val on the next edge
//   load_val in   CW-bit value to load
//   dec      in   decrement by one on the next edge
//   zero     out  count is 0
module pulse_stretch_cnt #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] cnt;

  // The FSM never asks for a decrement at zero, so no wrap guard here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_stretch_fsm.sv
// pulse_stretch_fsm
//   Converts a single-cycle tick into a HIGH_CYCLES-wide level pulse followed
//   by a GAP_CYCLES low guard gap. Moore FSM; outputs decode from registers.
//   clk      in   system clock
//   reset_n  in   async active-low reset
//   tick     in   single-cycle request
//   level    out  stretched pulse
//   busy     out  high in HIGH or GAP
//   missed   out  one-cycle flag after a dropped tick
//   Build option: PULSE_STRETCH_RETRIGGER_EN -- a tick in HIGH or GAP
//   (re)starts a full HIGH_CYCLES pulse and missed stays 0.
module pulse_stretch_fsm
  import pulse_stretch_pkg::*;
#(
  parameter int HIGH_CYCLES = HIGH_CYCLES_DEF,
  parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
  parameter int CW          = CW_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  output logic level,
  output logic busy,
  output logic missed
);

`ifdef PULSE_STRETCH_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  localparam logic [CW-1:0] HIGH_LOAD = CW'(HIGH_CYCLES - 1);
  // GAP_CYCLES==0 skips GAP entirely, so its load value is never used.
  localparam logic [CW-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

  state_t        state_q, state_d;
  logic          load, dec, zero;
  logic [CW-1:0] load_val;
  logic          missed_q, missed_d;

  pulse_stretch_cnt #(.CW(CW)) u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .load_val (load_val),
    .dec      (dec),
    .zero     (zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      missed_q <= missed_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = HIGH_LOAD;
    dec      = 1'b0;
    missed_d = !RETRIG && tick && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = HIGH;
          load    = 1'b1;
        end
      end
      HIGH: begin
        if (RETRIG && tick) begin
          load = 1'b1;
        end else if (zero) begin
          // Counter already sits at 0, so IDLE needs no reload.
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d  = GAP;
            load     = 1'b1;
            load_val = GAP_LOAD;
          end
        end else begin
          dec = 1'b1;
        end
      end
      GAP: begin
        if (RETRIG && tick) begin
          state_d = HIGH;
          load    = 1'b1;
        end else if (zero) begin
          state_d = IDLE;
        end else begin
          dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign level  = (state_q == HIGH);
  assign busy   = (state_q != IDLE);
  assign missed = missed_q;

endmodule

// File: tb/tb_pulse_stretch_fsm.sv
// tb_pulse_stretch_fsm
//   Three instances: d0 default (8 high / 2 gap), d1 HIGH=1 GAP=0,
//   d2 HIGH=255 GAP=2. Reference model tracks, per instance, the edge index
//   of the last accepted tick and derives outputs arithmetically from it.
module tb_pulse_stretch_fsm;

`ifdef PULSE_STRETCH_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] tick_v = 3'b000;
  wire  [2:0] level_v, busy_v, missed_v;

  always #5 clk = ~clk;

  pulse_stretch_fsm #(.HIGH_CYCLES(8), .GAP_CYCLES(2), .CW(8)) u_d0 (
    .clk(clk), .reset_n(reset_n), .tick(tick_v[0]),
    .level(level_v[0]), .busy(busy_v[0]), .missed(missed_v[0]));
  pulse_stretch_fsm #(.HIGH_CYCLES(1), .GAP_CYCLES(0), .CW(8)) u_d1 (
    .clk(clk), .reset_n(reset_n), .tick(tick_v[1]),
    .level(level_v[1]), .busy(busy_v[1]), .missed(missed_v[1]));
  pulse_stretch_fsm #(.HIGH_CYCLES(255), .GAP_CYCLES(2), .CW(8)) u_d2 (
    .clk(clk), .reset_n(reset_n), .tick(tick_v[2]),
    .level(level_v[2]), .busy(busy_v[2]), .missed(missed_v[2]));

  int tests = 0;
  int fails = 0;

  int H[3] = '{8, 1, 255};
  int G[3] = '{2, 0, 2};
  int e = 0;
  int s_acc[3];
  bit m_level[3], m_busy[3], m_missed[3];

  typedef struct {
    logic tick;
    logic level;
    logic busy;
    logic missed;
  } vec_t;
  vec_t vt[14];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      s_acc[i]    = -100000;
      m_level[i]  = 1'b0;
      m_busy[i]   = 1'b0;
      m_missed[i] = 1'b0;
    end
  endtask

  // A tick is taken when the block was idle before the edge (or always, with
  // retrigger); outputs follow from the distance to the last accepted edge.
  task automatic model_edge(input logic [2:0] t);
    bit acc;
    e++;
    for (int i = 0; i < 3; i++) begin
      acc         = t[i] && (RETRIG || !m_busy[i]);
      m_missed[i] = t[i] && !acc;
      if (acc) s_acc[i] = e;
      m_level[i]  = (e - s_acc[i]) < H[i];
      m_busy[i]   = (e - s_acc[i]) < (H[i] + G[i]);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s d%0d level", tag, i),  int'(level_v[i]),  int'(m_level[i]));
      chk($sformatf("%s d%0d busy", tag, i),   int'(busy_v[i]),   int'(m_busy[i]));
      chk($sformatf("%s d%0d missed", tag, i), int'(missed_v[i]), int'(m_missed[i]));
    end
  endtask

  task automatic step(input logic [2:0] t, input string tag);
    tick_v = t;
    @(posedge clk);
    model_edge(t);
    #1;
    check_all(tag);
  endtask

  initial begin
    int cnt;

    vt = '{
      '{1'b1, 1'b1, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b1, 1'b0},
      '{1'b0, 1'b1, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b1, 1'b0},
      '{1'b0, 1'b1, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b1, 1'b0},
      '{1'b0, 1'b1, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b1, 1'b0},
      '{1'b0, 1'b0, 1'b1, 1'b0}, '{1'b0, 1'b0, 1'b1, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b0, 1'b0}};

    // Reset held with tick high: everything reads 0.
    model_reset();
    reset_n = 1'b0;
    tick_v  = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset d%0d level", i),  int'(level_v[i]),  0);
      chk($sformatf("reset d%0d busy", i),   int'(busy_v[i]),   0);
      chk($sformatf("reset d%0d missed", i), int'(missed_v[i]), 0);
    end
    tick_v  = 3'b000;
    reset_n = 1'b1;
    step(3'b000, "idle");

    // Single pulse on d0 from the vector table.
    for (int k = 0; k < 14; k++) begin
      tick_v = {2'b00, vt[k].tick};
      @(posedge clk);
      model_edge({2'b00, vt[k].tick});
      #1;
      chk($sformatf("vec%0d level", k),  int'(level_v[0]),  int'(vt[k].level));
      chk($sformatf("vec%0d busy", k),   int'(busy_v[0]),   int'(vt[k].busy));
      chk($sformatf("vec%0d missed", k), int'(missed_v[0]), int'(vt[k].missed));
    end

    // Ticks 11 edges apart: two full pulses, nothing dropped.
    cnt = 0;
    for (int k = 0; k < 24; k++) begin
      step({2'b00, (k == 0 || k == 11)}, "spacing");
      cnt += int'(level_v[0]);
    end
    chk("spacing high count", cnt, 16);

    // Ticks at offsets 0, 3, 9.
    for (int k = 0; k < 16; k++) begin
      step({2'b00, (k == 0 || k == 3 || k == 9)}, "drop");
      if (k == 3 || k == 9) chk($sformatf("drop missed@%0d", k), int'(missed_v[0]), RETRIG ? 0 : 1);
    end

    // Ticks at offsets 0 and 5: 13 continuous highs with retrigger, 8 without.
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step({2'b00, (k == 0 || k == 5)}, "retrig");
      cnt += int'(level_v[0]);
    end
    chk("retrig high count", cnt, RETRIG ? 13 : 8);

    // HIGH=1, GAP=0: ticks every 2 edges all accepted, then every edge.
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step({1'b0, (k % 2 == 0), 1'b0}, "h1 every2");
      cnt += int'(level_v[1]);
    end
    chk("h1 every2 high count", cnt, 10);
    for (int k = 0; k < 10; k++) step(3'b010, "h1 every1");
    step(3'b000, "h1 tail");

    // HIGH=255: exactly 255 high cycles, no wrap.
    cnt = 0;
    for (int k = 0; k < 262; k++) begin
      step({(k == 0), 2'b00}, "h255");
      cnt += int'(level_v[2]);
    end
    chk("h255 high count", cnt, 255);

    // Reset in the 4th high cycle drops level asynchronously.
    for (int k = 0; k < 4; k++) step({2'b00, (k == 0)}, "midrst pre");
    chk("midrst level before", int'(level_v[0]), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst level async", int'(level_v[0]), 0);
    chk("midrst busy async", int'(busy_v[0]), 0);
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    step(3'b000, "midrst idle");
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      step({2'b00, (k == 0)}, "midrst post");
      cnt += int'(level_v[0]);
    end
    chk("midrst post high count", cnt, 8);

    // Random ticks on all three instances against the model.
    for (int k = 0; k < 1500; k++)
      step({($urandom_range(0, 99) < 3), ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0)}, "rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
